// File: rtl/idwt_row_serializer.sv
// Two-slot block buffer that turns 8x64-bit IDWT blocks into a valid/ready row stream.
// Optional raster word address output enabled by defining IDWT_SER_ADDR_OUT_EN.
module idwt_row_serializer #(
   parameter int NUM_BLOCKS      = 1024,
   parameter int BLOCKS_PER_LINE = 32,
   parameter int ADDR_W          = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [63:0]       inp1,
   input  logic [63:0]       inp2,
   input  logic [63:0]       inp3,
   input  logic [63:0]       inp4,
   input  logic [63:0]       inp5,
   input  logic [63:0]       inp6,
   input  logic [63:0]       inp7,
   input  logic [63:0]       inp8,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [63:0]       out_data,
   output logic              out_last,
`ifdef IDWT_SER_ADDR_OUT_EN
   output logic [ADDR_W-1:0] out_addr,
`endif
   output logic              frame_done,
   output logic              overflow
);

   localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

   if (NUM_BLOCKS < 1 || BLOCKS_PER_LINE < 1 || ADDR_W < 1) begin : g_param_check
      $error("idwt_row_serializer: parameters must be positive");
   end

   // Handshake: a row transfers on a cycle where out_valid && out_ready at the rising edge.
   logic [63:0]      slot_q [2][8];
   logic [63:0]      in_rows [8];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic [2:0]       row_cnt_q, row_cnt_d;
   logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
   logic             frame_done_q, frame_done_d;
   logic             overflow_q, overflow_d;

   logic hs, last_hs, capture, drop, blk_wrap;

   always_comb begin
      in_rows[0] = inp1;
      in_rows[1] = inp2;
      in_rows[2] = inp3;
      in_rows[3] = inp4;
      in_rows[4] = inp5;
      in_rows[5] = inp6;
      in_rows[6] = inp7;
      in_rows[7] = inp8;
   end

   assign out_valid  = (count_q != 2'd0);
   assign out_data   = slot_q[rd_ptr_q][row_cnt_q];
   assign out_last   = out_valid && (row_cnt_q == 3'd7);
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;

   assign hs       = out_valid && out_ready;
   assign last_hs  = hs && (row_cnt_q == 3'd7);
   // A full buffer can still accept when the head block frees its slot this same edge.
   assign capture  = in_valid && (!count_q[1] || last_hs);
   assign drop     = in_valid && count_q[1] && !last_hs;
   assign blk_wrap = (blk_cnt_q == BLK_W'(NUM_BLOCKS - 1));

   always_comb begin
      count_d = count_q;
      if (capture && !last_hs) begin
         count_d = count_q + 2'd1;
      end else if (!capture && last_hs) begin
         count_d = count_q - 2'd1;
      end
      wr_ptr_d     = wr_ptr_q ^ capture;
      rd_ptr_d     = rd_ptr_q ^ last_hs;
      row_cnt_d    = hs ? row_cnt_q + 3'd1 : row_cnt_q;
      blk_cnt_d    = blk_cnt_q;
      if (last_hs) begin
         blk_cnt_d = blk_wrap ? '0 : blk_cnt_q + BLK_W'(1);
      end
      frame_done_d = last_hs && blk_wrap;
      overflow_d   = overflow_q || drop;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         row_cnt_q    <= 3'd0;
         blk_cnt_q    <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         row_cnt_q    <= row_cnt_d;
         blk_cnt_q    <= blk_cnt_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < 8; i++) begin
            slot_q[wr_ptr_q][i] <= in_rows[i];
         end
      end
   end

`ifdef IDWT_SER_ADDR_OUT_EN
   // Block column/row tracked incrementally so no divider is needed.
   logic [BLK_W-1:0]  bx_q, bx_d;
   logic [BLK_W-1:0]  by_q, by_d;
   logic [ADDR_W-1:0] addr_w;

   always_comb begin
      bx_d = bx_q;
      by_d = by_q;
      if (last_hs) begin
         if (blk_wrap) begin
            bx_d = '0;
            by_d = '0;
         end else if (bx_q == BLK_W'(BLOCKS_PER_LINE - 1)) begin
            bx_d = '0;
            by_d = by_q + BLK_W'(1);
         end else begin
            bx_d = bx_q + BLK_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bx_q <= '0;
         by_q <= '0;
      end else begin
         bx_q <= bx_d;
         by_q <= by_d;
      end
   end

   assign addr_w   = ((ADDR_W'(by_q) * ADDR_W'(8) + ADDR_W'(row_cnt_q))
                      * ADDR_W'(BLOCKS_PER_LINE)) + ADDR_W'(bx_q);
   assign out_addr = addr_w;
`endif

endmodule

// File: tb/tb_idwt_row_serializer.sv
// Randomized bench for idwt_row_serializer against a row-queue reference model.
module tb_idwt_row_serializer;

   localparam int NB  = 1024;
   localparam int BPL = 32;
   localparam int AW  = 13;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] in_rows [8];
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_last;
   logic        frame_done;
   logic        overflow;
`ifdef IDWT_SER_ADDR_OUT_EN
   logic [AW-1:0] out_addr;
`endif

   always #5 clk = ~clk;

   idwt_row_serializer #(
      .NUM_BLOCKS(NB), .BLOCKS_PER_LINE(BPL), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .inp1(in_rows[0]), .inp2(in_rows[1]), .inp3(in_rows[2]), .inp4(in_rows[3]),
      .inp5(in_rows[4]), .inp6(in_rows[5]), .inp7(in_rows[6]), .inp8(in_rows[7]),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last),
`ifdef IDWT_SER_ADDR_OUT_EN
      .out_addr(out_addr),
`endif
      .frame_done(frame_done), .overflow(overflow)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   int          rows_done = 0;
   bit          ovf_exp   = 1'b0;
   bit          fd_exp    = 1'b0;
   bit          chk_en    = 1'b0;
   int          fd_seen   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (rows_done=%0d)", tag, got, exp, rows_done);
      end
   endtask

   // Called just after a falling edge: check outputs, drive inputs, advance the model.
   task automatic cycle(input bit v, input bit r, input bit rn);
      int head_row;
      int held;
      int blk;
      bit hs;
      bit last_hs;
      head_row = rows_done % 8;
      if (chk_en) begin
         check_eq("out_valid", out_valid, 64'(exp_q.size() != 0));
         check_eq("out_last", out_last, 64'((exp_q.size() != 0) && head_row == 7));
         check_eq("frame_done", frame_done, 64'(fd_exp));
         check_eq("overflow", overflow, 64'(ovf_exp));
         if (exp_q.size() != 0) begin
            check_eq("out_data", out_data, exp_q[0]);
`ifdef IDWT_SER_ADDR_OUT_EN
            blk = (rows_done / 8) % NB;
            check_eq("out_addr", 64'(out_addr), 64'(((blk / BPL) * 8 + head_row) * BPL + blk % BPL));
`endif
         end
      end
      if (frame_done === 1'b1) fd_seen++;

      rst_n     = rn;
      in_valid  = v;
      out_ready = r;
      for (int i = 0; i < 8; i++) begin
         in_rows[i] = {32'($urandom), 24'($urandom), 8'(i)};
      end

      if (!rn) begin
         exp_q.delete();
         rows_done = 0;
         ovf_exp   = 1'b0;
         fd_exp    = 1'b0;
      end else begin
         hs      = (exp_q.size() != 0) && r;
         last_hs = hs && (head_row == 7);
         held    = (exp_q.size() + 7) / 8;
         fd_exp  = last_hs && (((rows_done / 8) % NB) == NB - 1);
         if (hs) begin
            void'(exp_q.pop_front());
            rows_done++;
         end
         if (v) begin
            if (held < 2 || last_hs) begin
               for (int i = 0; i < 8; i++) exp_q.push_back(in_rows[i]);
            end else begin
               ovf_exp = 1'b1;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) in_rows[i] = '0;
      @(negedge clk);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      chk_en = 1'b1;

      // single block, always ready
      cycle(1, 1, 1);
      repeat (10) cycle(0, 1, 1);

      // three back-to-back blocks: third one is dropped
      repeat (3) cycle(1, 1, 1);
      repeat (24) cycle(0, 1, 1);

      // stall pattern inside a block
      cycle(1, 1, 1);
      cycle(0, 1, 1);
      cycle(0, 0, 1);
      cycle(0, 0, 1);
      cycle(0, 1, 1);
      repeat (10) cycle(0, 1, 1);

      // random mix with frequent overlap
      for (int c = 0; c < 400; c++) begin
         cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6), 1);
      end

      // full frame streamed with gaps
      cycle(0, 0, 0);
      fd_seen = 0;
      for (int c = 0; c < 40000 && rows_done < 8200; c++) begin
         cycle(($urandom_range(0, 11) == 0), ($urandom_range(0, 9) != 0), 1);
      end
      check_eq("stream_budget", 64'(rows_done >= 8200), 64'd1);
      check_eq("frame_done_pulses", 64'(fd_seen), 64'd1);

      // reset part-way through a block with in_valid held high
      cycle(0, 0, 0);
      cycle(1, 1, 1);
      repeat (4) cycle(0, 1, 1);
      cycle(1, 1, 0);
      cycle(0, 1, 1);
      cycle(1, 1, 1);
      repeat (10) cycle(0, 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/idwt_row_serializer.md
IDWT_ROW_SERIALIZER -- requirements
Module: idwt_row_serializer

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 1024, giving the number of 8x8 blocks per frame.
REQ-002 SHALL have parameter BLOCKS_PER_LINE, default 32, giving the number of blocks per image block-row.
REQ-003 SHALL have parameter ADDR_W, default 13, giving the width of out_addr in 64-bit words.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  a full 8-row block is present on inp1..inp8 (driven by the IDWT idwt_valid).
REQ-007 inp1..inp8  input  64 each  block rows 0..7, 8 pixels per row, pixel 0 in bits [63:56].
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid row.
REQ-010 out_data  output  64  current row.
REQ-011 out_last  output  1  current row is row 7 of its block.
REQ-012 out_addr  output  ADDR_W  raster word address of current row (present only with ADDR_OUT_EN).
REQ-013 frame_done  output  1  one-cycle pulse after the last row of block NUM_BLOCKS-1 is accepted.
REQ-014 overflow  output  1  sticky flag: a block was dropped.

Function
REQ-015 SHALL hold two block slots (8x64 each), plus a write pointer, a read pointer and an occupancy count of 0..2.
REQ-016 SHALL capture inp1..inp8 into the write slot on a rising edge with in_valid=1 when count<2; count increments and the write pointer toggles.
REQ-017 With count==2 and in_valid=1, SHALL capture the block if the head block's row 7 is handshaken in the same cycle; count stays 2.
REQ-018 Otherwise SHALL drop a block arriving with count==2 and set overflow; stored data SHALL be unaffected.
REQ-019 out_valid SHALL equal (count!=0); a captured block SHALL give out_valid=1 on the cycle after capture when the buffer was empty (latency 1).
REQ-020 out_data SHALL be row[row_cnt] of the read slot, emitted rows 0..7 in order (inp1 first).
REQ-021 A handshake SHALL be out_valid && out_ready; row_cnt advances only on a handshake.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_last and out_addr SHALL stay stable.
REQ-023 On a handshake with row_cnt==7: row_cnt->0, read pointer toggles, count decrements (unless REQ-017 applies), and blk_cnt increments.
REQ-024 blk_cnt SHALL wrap from NUM_BLOCKS-1 to 0; frame_done SHALL pulse high for exactly the cycle after that handshake.
REQ-025 out_last SHALL be (row_cnt==7) && out_valid.
REQ-026 With defaults, out_addr SHALL be ((by*8+row_cnt)*BLOCKS_PER_LINE + bx), where bx=blk_cnt mod BLOCKS_PER_LINE and by=blk_cnt / BLOCKS_PER_LINE.
REQ-027 in_valid with count==0 and out_ready=1 SHALL still need one cycle before row 0 appears; no combinational path from inp* to out_data.

Reset
REQ-028 On rising edge with rst_n=0: count, both pointers, row_cnt and blk_cnt SHALL be 0, and out_valid, out_last, frame_done and overflow SHALL be 0.
REQ-029 in_valid SHALL be ignored in any cycle where rst_n=0; a reset mid-block SHALL discard all buffered rows.
REQ-030 Slot contents need no reset; out_data is don't-care while out_valid=0.

Configuration
REQ-031 Macro IDWT_SER_ADDR_OUT_EN: when defined, the out_addr port and its address logic SHALL exist as in REQ-026.
REQ-032 When IDWT_SER_ADDR_OUT_EN is undefined, out_addr SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Single block (rows 0x..00 through 0x..07 tagged), out_ready=1 -> out_valid one cycle after capture, 8 consecutive rows in order, out_last on the 8th, blk_cnt=1.
REQ-034 in_valid every cycle for 3 cycles, out_ready=1 -> blocks 0 and 1 output in full, block 2 dropped unless it coincides with a row-7 handshake, overflow=1 if dropped and staying 1 until reset.
REQ-035 out_ready toggled 1,0,0,1 during a block -> a row is held stable across stall cycles and no row is lost or duplicated.
REQ-036 1024 blocks streamed with gaps -> frame_done single pulse after the 8192nd row; with ADDR_OUT_EN, block 33 row 2 gives out_addr=(1*8+2)*32+1=321, and the last row gives 8191.
REQ-037 rst_n=0 asserted after row 3 of a block, in_valid=1 during reset -> out_valid=0 the next cycle, and a fresh block afterwards starts at row 0 with out_addr 0.
